// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: N-channel valid/ready merge onto one registered stream,
// round-robin or fixed-priority selection with optional packet locking.
module stream_rr_arbiter #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int MODE     = 0,
    parameter int LOCK_PKT = 1,
    localparam int IW      = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_valid,
    input  logic [N*W-1:0] i_data,
    input  logic [N-1:0]   i_last,
    output logic [N-1:0]   o_ready,
    output logic           o_valid,
    output logic [W-1:0]   o_data,
    output logic           o_last,
    output logic [IW-1:0]  o_src,
    input  logic           i_ready
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] sel, k;
    logic          found, load, accept, sel_last;
    logic [W-1:0]  sel_data;

    // No grants while reset is held, even though o_valid is already low.
    assign load   = !i_rst && (!o_valid || i_ready);
    assign accept = load && found;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        k     = '0;
        if (state_q == LOCKED) begin
            found = i_valid[owner_q];
            sel   = owner_q;
        end else if (MODE == 1) begin
            for (int i = N - 1; i >= 0; i--) begin
                k = IW'(i);
                if (i_valid[k]) begin
                    found = 1'b1;
                    sel   = k;
                end
            end
        end else begin
            // Walk backwards so the smallest offset from ptr wins.
            for (int i = N - 1; i >= 0; i--) begin
                k = IW'((int'(ptr_q) + i) % N);
                if (i_valid[k]) begin
                    found = 1'b1;
                    sel   = k;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        o_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == sel) begin
                sel_data = i_data[i*W +: W];
                sel_last = i_last[i];
            end
        end
        if (accept) begin
            o_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (LOCK_PKT != 0 && accept) begin
            state_d = sel_last ? IDLE : LOCKED;
            owner_d = sel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_src   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (accept) begin
                ptr_q <= (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
            end
            if (load) begin
                o_valid <= found;
                if (found) begin
                    o_data <= sel_data;
                    o_last <= sel_last;
                    o_src  <= sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: reset, round-robin, backpressure,
// packet lock, fixed priority, lock-free passthrough, reset mid-packet.
module tb_stream_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   last;
    logic           ready;

    logic [N-1:0] a_rdy, f_rdy, n_rdy;
    logic         a_vld, f_vld, n_vld;
    logic [W-1:0] a_dat, f_dat, n_dat;
    logic         a_lst, f_lst, n_lst;
    logic [1:0]   a_src, f_src, n_src;

    int n_run  = 0;
    int n_fail = 0;

    stream_rr_arbiter #(.N(N), .W(W), .MODE(0), .LOCK_PKT(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
        .i_last(last), .o_ready(a_rdy), .o_valid(a_vld), .o_data(a_dat),
        .o_last(a_lst), .o_src(a_src), .i_ready(ready)
    );

    stream_rr_arbiter #(.N(N), .W(W), .MODE(1), .LOCK_PKT(0)) u_fp (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
        .i_last(last), .o_ready(f_rdy), .o_valid(f_vld), .o_data(f_dat),
        .o_last(f_lst), .o_src(f_src), .i_ready(ready)
    );

    stream_rr_arbiter #(.N(N), .W(W), .MODE(0), .LOCK_PKT(0)) u_nl (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
        .i_last(last), .o_ready(n_rdy), .o_valid(n_vld), .o_data(n_dat),
        .o_last(n_lst), .o_src(n_src), .i_ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dv(input int c);
        return 32'hC0DE_0000 | c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        valid = 4'hF;
        last  = 4'hF;
        ready = 1'b1;
        for (int c = 0; c < N; c++) data[c*W +: W] = dv(c);

        // reset held two cycles with every channel requesting
        tick;
        check("rst1_vld", a_vld, 0);
        check("rst1_rdy", a_rdy, 0);
        tick;
        check("rst2_vld", a_vld, 0);
        check("rst2_rdy", a_rdy, 0);
        check("rst_dat", a_dat, 0);
        check("rst_src", a_src, 0);
        check("rst_lst", a_lst, 0);
        rst = 1'b0;

        // round robin, one beat per cycle
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr%0d_rdy", i), a_rdy, 4'b0001 << (i % 4));
            tick;
            check($sformatf("rr%0d_vld", i), a_vld, 1);
            check($sformatf("rr%0d_src", i), a_src, i % 4);
            check($sformatf("rr%0d_dat", i), a_dat, dv(i % 4));
        end

        // backpressure holding the ch3 beat
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d_rdy", i), a_rdy, 0);
            tick;
            check($sformatf("bp%0d_vld", i), a_vld, 1);
            check($sformatf("bp%0d_src", i), a_src, 3);
            check($sformatf("bp%0d_dat", i), a_dat, dv(3));
        end
        ready = 1'b1;
        #1;
        check("bp_rel_rdy", a_rdy, 4'b0001);
        tick;
        check("bp_rel_src", a_src, 0);

        // ch1 single beat moves ptr to 2
        valid = 4'b0010;
        #1;
        check("pre_rdy", a_rdy, 4'b0010);
        tick;
        check("pre_src", a_src, 1);

        // ch2 three-beat packet with a gap; ch0/ch1 keep requesting
        valid = 4'b0111;
        last  = 4'b1011;
        data[2*W +: W] = 32'hB200_0001;
        #1;
        check("pk1_rdy", a_rdy, 4'b0100);
        tick;
        check("pk1_src", a_src, 2);
        check("pk1_dat", a_dat, 32'hB200_0001);
        check("pk1_lst", a_lst, 0);
        valid = 4'b0011;
        #1;
        check("pkgap_rdy", a_rdy, 0);
        tick;
        check("pkgap_vld", a_vld, 0);
        valid = 4'b0111;
        data[2*W +: W] = 32'hB200_0002;
        #1;
        check("pk2_rdy", a_rdy, 4'b0100);
        tick;
        check("pk2_src", a_src, 2);
        check("pk2_dat", a_dat, 32'hB200_0002);
        data[2*W +: W] = 32'hB200_0003;
        last  = 4'b1111;
        #1;
        check("pk3_rdy", a_rdy, 4'b0100);
        tick;
        check("pk3_src", a_src, 2);
        check("pk3_lst", a_lst, 1);
        valid = 4'b0011;
        #1;
        check("pkend_rdy", a_rdy, 4'b0001);
        tick;
        check("pkend_src", a_src, 0);

        // lock on ch1 then reset mid-packet
        last = 4'b1101;
        #1;
        check("mr_rdy", a_rdy, 4'b0010);
        tick;
        check("mr_src", a_src, 1);
        rst = 1'b1;
        #1;
        check("mr_rst_rdy", a_rdy, 0);
        tick;
        check("mr_rst_vld", a_vld, 0);
        rst   = 1'b0;
        valid = 4'b1001;
        last  = 4'b1111;
        #1;
        check("mr_post_rdy", a_rdy, 4'b0001);
        tick;
        check("mr_post_vld", a_vld, 1);
        check("mr_post_src", a_src, 0);

        // fresh reset for lock-free and fixed-priority instances
        rst = 1'b1;
        tick;
        rst   = 1'b0;
        valid = 4'b0011;
        last  = 4'b0000;
        #1;
        check("nl1_rdy", n_rdy, 4'b0001);
        check("lk1_rdy", a_rdy, 4'b0001);
        tick;
        check("nl1_src", n_src, 0);
        check("nl1_lst", n_lst, 0);
        #1;
        check("nl2_rdy", n_rdy, 4'b0010);
        check("lk2_rdy", a_rdy, 4'b0001);
        tick;
        check("nl2_src", n_src, 1);
        check("nl2_dat", n_dat, dv(1));

        valid = 4'b1010;
        last  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fp%0d_rdy", i), f_rdy, 4'b0010);
            tick;
            check($sformatf("fp%0d_src", i), f_src, 1);
        end
        valid = 4'b1000;
        #1;
        check("fp_drop_rdy", f_rdy, 4'b1000);
        tick;
        check("fp_drop_src", f_src, 3);
        check("fp_drop_dat", f_dat, dv(3));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
